// File: rtl/operand_loader_if.sv
// operand_loader_if
//   Bundles the slide-switch / push-button inputs and the operand outputs of
//   the operand loader so the front-end connects to the rest of the ALU demo
//   through a single port.
//
//   Signals:
//     switch      [9:0]   raw slide-switch levels
//     b0_n/b1_n/b2_n      raw push-buttons, low = pressed (load A / B / C)
//     a_reg       [N-1:0] operand A
//     b_reg       [N-1:0] operand B
//     c_reg       [9:0]   control word C
//     load_strobe [2:0]   one-cycle write pulse, bit k = register k written
//     held                high while waiting for all buttons to be released
//
//   Modports:
//     master  drives the raw inputs and observes the operands (board / bench)
//     slave   the operand loader itself
interface operand_loader_if #(
    parameter int N = 4
);
    logic [9:0]   switch;
    logic         b0_n;
    logic         b1_n;
    logic         b2_n;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [9:0]   c_reg;
    logic [2:0]   load_strobe;
    logic         held;

    modport master (
        output switch, b0_n, b1_n, b2_n,
        input  a_reg, b_reg, c_reg, load_strobe, held
    );

    modport slave (
        input  switch, b0_n, b1_n, b2_n,
        output a_reg, b_reg, c_reg, load_strobe, held
    );
endinterface

// File: rtl/operand_loader.sv
// operand_loader
//   Clocked input front-end for the ALU demo. The three active-low buttons
//   and the ten slide switches are brought into the clock domain with
//   two-flop synchronisers, each button is debounced independently, and a
//   clean press of exactly one button copies the synchronised switch value
//   into operand A, B or the control word C. After a load the block waits in
//   HELD until every button has been released, so one press gives one load.
//
//   Parameters:
//     N                operand width of A and B (1..10), taken from switch[N-1:0]
//     DEBOUNCE_CYCLES  cycles a synchronised level must stay stable (>= 2)
//     DB_W             debounce counter width, must hold DEBOUNCE_CYCLES
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    operand_loader_if slave modport (switches, buttons, operands,
//            load_strobe, held)
module operand_loader #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    operand_loader_if.slave     bus
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_C,
        HELD
    } state_t;

    logic [2:0]      btn_raw;
    logic [2:0]      btn_s1;
    logic [2:0]      btn_s2;
    logic [9:0]      sw_s1;
    logic [9:0]      sw_s2;

    logic [2:0]      db_lvl;
    logic [2:0]      db_prev;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [9:0]      c_q;

    assign btn_raw = {bus.b2_n, bus.b1_n, bus.b0_n};

    // Two-flop synchronisers. Buttons reset to the released level so that a
    // button held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 3'b111;
            btn_s2 <= 3'b111;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= bus.switch;
            sw_s2  <= sw_s1;
        end
    end

    // Per-button debounce. The counter only runs while the synchronised level
    // disagrees with the accepted level; any bounce back clears it, so the
    // new level must persist for DEBOUNCE_CYCLES consecutive cycles.
    // db_prev is a one-cycle delayed copy used to spot the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl  <= 3'b111;
            db_prev <= 3'b111;
            for (int k = 0; k < 3; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            db_prev <= db_lvl;
            for (int k = 0; k < 3; k++) begin
                if (btn_s2[k] == db_lvl[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_lvl[k] <= btn_s2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // A press event lasts exactly the one cycle after the debounced level
    // has fallen.
    assign press = db_prev & ~db_lvl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A load is only accepted when exactly one button has
    // just been pressed and the other two are fully released; anything else
    // (including simultaneous presses) is ignored in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (press == 3'b001 && db_lvl == 3'b110) begin
                    state_next = LOAD_A;
                end else if (press == 3'b010 && db_lvl == 3'b101) begin
                    state_next = LOAD_B;
                end else if (press == 3'b100 && db_lvl == 3'b011) begin
                    state_next = LOAD_C;
                end
            end
            LOAD_A, LOAD_B, LOAD_C: begin
                state_next = HELD;
            end
            HELD: begin
                if (db_lvl == 3'b111) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers are written on the edge that enters the LOAD state,
    // so they capture the synchronised switches seen at that edge and the new
    // value appears together with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            if (state_next == LOAD_A) begin
                a_q <= sw_s2[N-1:0];
            end
            if (state_next == LOAD_B) begin
                b_q <= sw_s2[N-1:0];
            end
            if (state_next == LOAD_C) begin
                c_q <= sw_s2;
            end
        end
    end

    assign bus.a_reg       = a_q;
    assign bus.b_reg       = b_q;
    assign bus.c_reg       = c_q;
    assign bus.load_strobe = {state == LOAD_C, state == LOAD_B, state == LOAD_A};
    assign bus.held        = (state == HELD);

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader
//   Directed bench for operand_loader with DEBOUNCE_CYCLES=4 and N=4.
//   A table of single-press vectors is applied in a loop, followed by
//   hand-written sequences for bounce, presses during HELD and reset while
//   HELD. Inputs change on the falling clock edge; outputs are sampled 1 time
//   unit after the rising edge.
module tb_operand_loader;

    localparam int N  = 4;
    localparam int DC = 4;

    typedef struct {
        logic [2:0] b_n;
        logic [9:0] sw;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [9:0] exp_c;
        logic [2:0] exp_strobe;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    vec_t vecs [5];

    operand_loader_if #(.N(N)) bus ();

    operand_loader #(
        .N(N),
        .DEBOUNCE_CYCLES(DC),
        .DB_W(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] b_n, input logic [9:0] sw);
        @(negedge clk);
        bus.b0_n   = b_n[0];
        bus.b1_n   = b_n[1];
        bus.b2_n   = b_n[2];
        bus.switch = sw;
    endtask

    task automatic sample_edge();
        @(posedge clk);
        #1;
    endtask

    // Drive a press on the next falling edge (first sampled at edge t), then
    // check nothing has fired by t+5, the load at t+6 and the strobe end at t+7.
    task automatic press_and_check(input string name, input logic [2:0] b_n,
                                   input logic [9:0] sw, input logic [3:0] exp_a,
                                   input logic [3:0] exp_b, input logic [9:0] exp_c,
                                   input logic [2:0] exp_stb);
        apply_stimulus(b_n, sw);
        repeat (DC + 2) sample_edge();
        check_output({name, " strobe early"}, 32'(bus.load_strobe), 32'h0);
        sample_edge();
        check_output({name, " a_reg"}, 32'(bus.a_reg), 32'(exp_a));
        check_output({name, " b_reg"}, 32'(bus.b_reg), 32'(exp_b));
        check_output({name, " c_reg"}, 32'(bus.c_reg), 32'(exp_c));
        check_output({name, " strobe"}, 32'(bus.load_strobe), 32'(exp_stb));
        sample_edge();
        check_output({name, " strobe one-shot"}, 32'(bus.load_strobe), 32'h0);
        check_output({name, " held"}, 32'(bus.held), (exp_stb != 3'b000) ? 32'h1 : 32'h0);
    endtask

    // Release every button and wait (bounded) for the FSM to leave HELD, then
    // give the debouncers time to settle before the next press.
    task automatic release_and_wait(input string name);
        int i;
        apply_stimulus(3'b111, 10'h000);
        i = 0;
        while (bus.held && i < 40) begin
            sample_edge();
            i++;
        end
        check_output({name, " back to idle"}, 32'(bus.held), 32'h0);
        repeat (10) sample_edge();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{b_n: 3'b110, sw: 10'h005, exp_a: 4'h5, exp_b: 4'h0, exp_c: 10'h000, exp_strobe: 3'b001};
        vecs[1] = '{b_n: 3'b010, sw: 10'h1FF, exp_a: 4'h5, exp_b: 4'h0, exp_c: 10'h000, exp_strobe: 3'b000};
        vecs[2] = '{b_n: 3'b011, sw: 10'h3C7, exp_a: 4'h5, exp_b: 4'h0, exp_c: 10'h3C7, exp_strobe: 3'b100};
        vecs[3] = '{b_n: 3'b101, sw: 10'h3FC, exp_a: 4'h5, exp_b: 4'hC, exp_c: 10'h3C7, exp_strobe: 3'b010};
        vecs[4] = '{b_n: 3'b110, sw: 10'h0F3, exp_a: 4'h3, exp_b: 4'hC, exp_c: 10'h3C7, exp_strobe: 3'b001};

        rst_n      = 1'b0;
        bus.b0_n   = 1'b1;
        bus.b1_n   = 1'b1;
        bus.b2_n   = 1'b1;
        bus.switch = 10'h000;
        #1;
        check_output("reset outputs", {bus.a_reg, bus.b_reg, bus.c_reg, bus.load_strobe, bus.held}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with all buttons released: nothing may change.
        for (int i = 0; i < 50; i++) begin
            sample_edge();
            check_output("idle outputs", {bus.a_reg, bus.b_reg, bus.c_reg, bus.load_strobe, bus.held}, 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            press_and_check($sformatf("vec%0d", i), vecs[i].b_n, vecs[i].sw, vecs[i].exp_a,
                            vecs[i].exp_b, vecs[i].exp_c, vecs[i].exp_strobe);
            repeat (12) sample_edge();
            if (vecs[i].exp_strobe != 3'b000) begin
                check_output($sformatf("vec%0d still held", i), 32'(bus.held), 32'h1);
            end
            release_and_wait($sformatf("vec%0d", i));
        end

        // Bounce on b1: low 2, high 1, low 2, high 1, then a steady press.
        begin
            logic [5:0] pattern;
            pattern = 6'b100100;
            for (int i = 0; i < 6; i++) begin
                apply_stimulus({1'b1, pattern[i], 1'b1}, 10'h00A);
                sample_edge();
                check_output("bounce no strobe", 32'(bus.load_strobe), 32'h0);
                check_output("bounce b_reg", 32'(bus.b_reg), 32'hC);
            end
        end
        press_and_check("bounce steady", 3'b101, 10'h00A, 4'h3, 4'hA, 10'h3C7, 3'b010);
        release_and_wait("bounce");

        // Presses during HELD are ignored.
        press_and_check("held A", 3'b110, 10'h007, 4'h7, 4'hA, 10'h3C7, 3'b001);
        apply_stimulus(3'b100, 10'h00E);
        for (int i = 0; i < 15; i++) begin
            sample_edge();
            check_output("held ignore b_reg", 32'(bus.b_reg), 32'hA);
            check_output("held ignore strobe", 32'(bus.load_strobe), 32'h0);
        end
        release_and_wait("held ignore");
        press_and_check("after held B", 3'b101, 10'h009, 4'h7, 4'h9, 10'h3C7, 3'b010);
        release_and_wait("after held B");

        // Reset while HELD, button kept low through reset.
        press_and_check("pre-reset A", 3'b110, 10'h005, 4'h5, 4'h9, 10'h3C7, 3'b001);
        #2;
        rst_n      = 1'b0;
        bus.switch = 10'h003;
        #1;
        check_output("async reset a_reg", 32'(bus.a_reg), 32'h0);
        check_output("async reset b/c", {bus.b_reg, bus.c_reg}, 32'h0);
        check_output("async reset held", 32'(bus.held), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DC + 2) sample_edge();
        check_output("post-reset early a_reg", 32'(bus.a_reg), 32'h0);
        sample_edge();
        check_output("post-reset a_reg", 32'(bus.a_reg), 32'h3);
        check_output("post-reset strobe", 32'(bus.load_strobe), 32'h1);
        sample_edge();
        check_output("post-reset held", 32'(bus.held), 32'h1);
        release_and_wait("post-reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Clocked input front-end for the ALU demo top.
- Synchronises and debounces the three active-low push-buttons and the 10 slide switches. On a clean, exclusive button press it writes the switch value into the A, B or C operand register.
- Outputs feed the ALU/LED/HEX datapath directly and replace the level-triggered register capture.
- Emits one-cycle load strobes for downstream use.

Parameters:
- N, 4, operand width of A/B registers (1..10); takes switch[N-1:0].
- DEBOUNCE_CYCLES, 50000, cycles a synchronised button level must stay stable before it is accepted (>=2).
- DB_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- switch  input  10  raw slide-switch levels
- b0_n  input  1  raw button 0, low = pressed (loads A)
- b1_n  input  1  raw button 1, low = pressed (loads B)
- b2_n  input  1  raw button 2, low = pressed (loads C)
- a_reg  output  N  operand A
- b_reg  output  N  operand B
- c_reg  output  10  control word C
- load_strobe  output  3  one-cycle pulse; bit k = register k written this cycle (0=A, 1=B, 2=C)
- held  output  1  high while in HELD state

Behaviour:
- Reset (async, rst_n low):
  - a_reg, b_reg, c_reg = 0; load_strobe = 0.
  - FSM = IDLE; held = 0.
  - Button sync flops = 1; switch sync flops = 0.
  - Debounced button levels = 1 (released); debounce counters = 0.
- Synchronisation: 2-flop synchroniser on each button and each switch bit. Only synchronised switch values are ever loaded.
- Debounce, per button, independent:
  - If the synchronised level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronised level and the counter clears.
  - Any bounce back to the debounced level restarts the count.
- Press event: debounced level transitions 1->0 (one cycle).
- FSM:
  - IDLE: exactly one press event this cycle AND the other two debounced levels = 1 -> LOAD(k). Zero or multiple simultaneous press events -> stay IDLE, no load.
  - LOAD(k), one cycle: the selected register gets the synchronised switch (a/b take [N-1:0], c takes [9:0]); load_strobe[k] = 1; next state HELD.
  - HELD: held = 1. Ignore all presses. Return to IDLE when all three debounced levels = 1.
- Latency: with a clean button low first sampled at edge t, the debounced level falls at edge t+1+DEBOUNCE_CYCLES. The FSM enters LOAD on the next edge; register and strobe are visible after edge t+2+DEBOUNCE_CYCLES.
- Value loaded: synchronised switch as seen on the edge that enters LOAD. Switch changes after that do not affect the stored value.
- Registers hold their values indefinitely; only their own LOAD writes them.
- Reset mid-debounce or mid-HELD: immediate return to reset values. A button still held low after reset release debounces as a fresh press and loads.
- Unused switch bits [9:N] are ignored for A/B.

Test Plan (DEBOUNCE_CYCLES=4, N=4):
- Reset then idle: all outputs 0; held=0 for 50 cycles with buttons high.
- switch=10'h005, b0_n low clean from edge t, held 20 cycles: a_reg=4'h5 and load_strobe=3'b001 for exactly one cycle after edge t+6; held=1 until b0_n released and debounced; b_reg, c_reg unchanged (0).
- b1_n bounce: low 2 cycles, high 1, low 2, high 1, then steady low with switch=10'h00A: no load during the bounce; b_reg=4'hA exactly 6 cycles after the steady low starts.
- b0_n and b2_n driven low on the same edge: no strobe, all registers unchanged. Release both, then press b2_n alone with switch=10'h3C7: c_reg=10'h3C7, load_strobe=3'b100.
- While HELD from b0_n, press b1_n: no B load. Release both, then press b1_n with switch=10'h009: b_reg=4'h9.
- Assert rst_n low while HELD with a_reg=4'h5: a_reg=0 and held=0 immediately, asynchronously. Deassert with b0_n still low and switch=10'h003: a_reg=4'h3 after the debounce latency.
